// File: rtl/bp_btb_wr_arbiter.sv
// BTB write-port arbiter: EX corrections win outright, ID fills are bypassed
// when idle or held in a small coalescing FIFO that EX writes can kill.
module bp_btb_wr_arbiter #(
    parameter int unsigned BTB_W  = 7,
    parameter int unsigned QDEPTH = 4
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             id_stall,
    input  logic                             refresh,
    input  logic                             id_btb_wen,
    input  logic [BTB_W-1:0]                 id_btb_windex,
    input  logic [31:0]                      id_btb_wtarget,
    input  logic                             ex_btb_wen,
    input  logic [BTB_W-1:0]                 ex_btb_windex,
    input  logic [31:0]                      ex_btb_wtarget,
    output logic                             btb_wen,
    output logic [BTB_W-1:0]                 btb_windex,
    output logic [31:0]                      btb_wtarget,
    output logic [$clog2(QDEPTH):0]          q_count,
    output logic [15:0]                      drop_cnt
);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    logic [QDEPTH-1:0] vld_q, vld_d, kill_q, kill_d, coal_match;
    logic [BTB_W-1:0]  idx_q [QDEPTH];
    logic [BTB_W-1:0]  idx_d [QDEPTH];
    logic [31:0]       tgt_q [QDEPTH];
    logic [31:0]       tgt_d [QDEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_after_pop;
    logic [15:0]       drop_q, drop_d;
    logic              wen_q, wen_d;
    logic [BTB_W-1:0]  windex_q, windex_d;
    logic [31:0]       wtarget_q, wtarget_d;

    logic idv, exv, q_empty, issue_head, silent_pop, bypass, pop;
    logic enq, ex_clash, coal_hit, push, drop_inc;

    always_comb begin
        idv        = id_btb_wen & ~id_stall & ~refresh;
        exv        = ex_btb_wen;
        q_empty    = (cnt_q == '0);
        // A flush suppresses the head pop, so the head is neither issued nor discarded.
        issue_head = ~exv & ~q_empty & ~kill_q[head_q] & ~refresh;
        silent_pop = ~exv & ~q_empty &  kill_q[head_q] & ~refresh;
        bypass     = ~exv & q_empty & idv;
        pop        = issue_head | silent_pop;
        cnt_after_pop = cnt_q - CW'(pop);

        enq      = idv & ~bypass;
        ex_clash = exv & (id_btb_windex == ex_btb_windex);
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            coal_match[i] = vld_q[i] & ~kill_q[i] & (idx_q[i] == id_btb_windex)
                          & ~(pop & (head_q == PW'(i)));
        end
        coal_hit = |coal_match;
        push     = enq & ~ex_clash & ~coal_hit & (cnt_after_pop < CW'(QDEPTH));
        drop_inc = enq & ~ex_clash & ~coal_hit & ~push;
    end

    always_comb begin
        vld_d  = vld_q;
        kill_d = kill_q;
        idx_d  = idx_q;
        tgt_d  = tgt_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_after_pop + CW'(push);
        drop_d = drop_q;

        for (int unsigned i = 0; i < QDEPTH; i++) begin
            if (exv && vld_q[i] && (idx_q[i] == ex_btb_windex)) kill_d[i] = 1'b1;
            if (enq && !ex_clash && coal_match[i]) tgt_d[i] = id_btb_wtarget;
        end
        if (pop) begin
            vld_d[head_q]  = 1'b0;
            kill_d[head_q] = 1'b0;
            head_d         = head_q + 1'b1;
        end
        // Push after pop so a full-queue push into the slot being freed wins.
        if (push) begin
            vld_d[tail_q]  = 1'b1;
            kill_d[tail_q] = 1'b0;
            idx_d[tail_q]  = id_btb_windex;
            tgt_d[tail_q]  = id_btb_wtarget;
            tail_d         = tail_q + 1'b1;
        end
        if (drop_inc && (drop_q != '1)) drop_d = drop_q + 16'd1;
        if (refresh) begin
            vld_d  = '0;
            kill_d = '0;
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end
    end

    always_comb begin
        wen_d     = exv | issue_head | bypass;
        windex_d  = windex_q;
        wtarget_d = wtarget_q;
        if (exv) begin
            windex_d  = ex_btb_windex;
            wtarget_d = ex_btb_wtarget;
        end else if (issue_head) begin
            windex_d  = idx_q[head_q];
            wtarget_d = tgt_q[head_q];
        end else if (bypass) begin
            windex_d  = id_btb_windex;
            wtarget_d = id_btb_wtarget;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q     <= '0;
            kill_q    <= '0;
            idx_q     <= '{default: '0};
            tgt_q     <= '{default: '0};
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            drop_q    <= '0;
            wen_q     <= 1'b0;
            windex_q  <= '0;
            wtarget_q <= '0;
        end else begin
            vld_q     <= vld_d;
            kill_q    <= kill_d;
            idx_q     <= idx_d;
            tgt_q     <= tgt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            wen_q     <= wen_d;
            windex_q  <= windex_d;
            wtarget_q <= wtarget_d;
        end
    end

    assign btb_wen     = wen_q;
    assign btb_windex  = windex_q;
    assign btb_wtarget = wtarget_q;
    assign q_count     = cnt_q;
    assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_bp_btb_wr_arbiter.sv
// Directed bench for the BTB write arbiter; expected writes go through a scoreboard queue.
module tb_bp_btb_wr_arbiter;
    localparam int unsigned BTB_W  = 7;
    localparam int unsigned QDEPTH = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic             id_stall, refresh;
    logic             id_btb_wen, ex_btb_wen;
    logic [BTB_W-1:0] id_btb_windex, ex_btb_windex;
    logic [31:0]      id_btb_wtarget, ex_btb_wtarget;
    logic             btb_wen;
    logic [BTB_W-1:0] btb_windex;
    logic [31:0]      btb_wtarget;
    logic [2:0]       q_count;
    logic [15:0]      drop_cnt;

    int total = 0;
    int bad   = 0;
    logic [BTB_W+31:0] exp_q[$];

    bp_btb_wr_arbiter #(.BTB_W(BTB_W), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .resetn(resetn), .id_stall(id_stall), .refresh(refresh),
        .id_btb_wen(id_btb_wen), .id_btb_windex(id_btb_windex), .id_btb_wtarget(id_btb_wtarget),
        .ex_btb_wen(ex_btb_wen), .ex_btb_windex(ex_btb_windex), .ex_btb_wtarget(ex_btb_wtarget),
        .btb_wen(btb_wen), .btb_windex(btb_windex), .btb_wtarget(btb_wtarget),
        .q_count(q_count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Every issued write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (btb_wen === 1'b1) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_write got=%h exp=none", {btb_windex, btb_wtarget});
            end
            if (exp_q.size() != 0) begin
                logic [BTB_W+31:0] e;
                e = exp_q.pop_front();
                total++;
                assert ({btb_windex, btb_wtarget} === e) else begin
                    bad++;
                    $error("FAIL wr_seq got=%h exp=%h", {btb_windex, btb_wtarget}, e);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic exe, input logic [BTB_W-1:0] exi, input logic [31:0] ext,
                         input logic ide, input logic [BTB_W-1:0] idi, input logic [31:0] idt);
        ex_btb_wen = exe; ex_btb_windex = exi; ex_btb_wtarget = ext;
        id_btb_wen = ide; id_btb_windex = idi; id_btb_wtarget = idt;
    endtask

    task automatic expect_wr(input logic [BTB_W-1:0] i, input logic [31:0] t);
        exp_q.push_back({i, t});
    endtask

    initial begin
        resetn = 1'b0; id_stall = 1'b0; refresh = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick(); tick();
        check("rst_wen", 32'(btb_wen), 32'd0);
        check("rst_idx", 32'(btb_windex), 32'd0);
        check("rst_tgt", btb_wtarget, 32'd0);
        check("rst_qcnt", 32'(q_count), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk); resetn = 1'b1;
        tick();

        // Bypass into an empty queue
        drive(0, 0, 0, 1, 7'd5, 32'h1000); expect_wr(7'd5, 32'h1000);
        tick(); drive(0, 0, 0, 0, 0, 0);
        check("byp_wen", 32'(btb_wen), 32'd1);
        check("byp_qcnt", 32'(q_count), 32'd0);
        tick();

        // EX priority over queued ID fills
        drive(1, 7'd3, 32'hE3, 1, 7'd9, 32'h900); expect_wr(7'd3, 32'hE3);
        tick();
        check("pri_qcnt1", 32'(q_count), 32'd1);
        drive(1, 7'd3, 32'hE4, 1, 7'd10, 32'hA00); expect_wr(7'd3, 32'hE4);
        tick();
        check("pri_qcnt2", 32'(q_count), 32'd2);
        drive(0, 0, 0, 0, 0, 0); expect_wr(7'd9, 32'h900); expect_wr(7'd10, 32'hA00);
        tick(); check("pri_drain1", 32'(q_count), 32'd1);
        tick(); check("pri_drain0", 32'(q_count), 32'd0);
        tick(); check("pri_idle", 32'(btb_wen), 32'd0);

        // Coalesce two fills of index 7
        drive(1, 7'd1, 32'h11, 1, 7'd7, 32'hAAAA); expect_wr(7'd1, 32'h11);
        tick();
        drive(1, 7'd1, 32'h12, 1, 7'd7, 32'hBBBB); expect_wr(7'd1, 32'h12);
        tick();
        check("coal_qcnt", 32'(q_count), 32'd1);
        drive(0, 0, 0, 0, 0, 0); expect_wr(7'd7, 32'hBBBB);
        tick(); check("coal_qcnt0", 32'(q_count), 32'd0);
        tick(); check("coal_single", 32'(btb_wen), 32'd0);

        // EX kill of a queued fill
        drive(1, 7'd2, 32'h21, 1, 7'd4, 32'h400); expect_wr(7'd2, 32'h21);
        tick();
        drive(1, 7'd4, 32'h44, 0, 0, 0); expect_wr(7'd4, 32'h44);
        tick();
        check("kill_qcnt", 32'(q_count), 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("kill_silent_wen", 32'(btb_wen), 32'd0);
        check("kill_qcnt0", 32'(q_count), 32'd0);
        tick();

        // Overflow while EX holds the port
        for (int k = 0; k < 6; k++) begin
            drive(1, 7'h20, 32'h2000 + 32'(k), 1, 7'(7'h30 + k), 32'h3000 + 32'(k));
            expect_wr(7'h20, 32'h2000 + 32'(k));
            tick();
        end
        check("ovf_qcnt", 32'(q_count), 32'd4);
        check("ovf_drop", 32'(drop_cnt), 32'd2);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) expect_wr(7'(7'h30 + k), 32'h3000 + 32'(k));
        repeat (4) tick();
        check("ovf_qcnt0", 32'(q_count), 32'd0);
        tick();

        // Stalled ID request issues once when released
        id_stall = 1'b1;
        drive(0, 0, 0, 1, 7'h15, 32'h1500);
        repeat (3) begin
            tick(); check("stall_wen", 32'(btb_wen), 32'd0);
        end
        id_stall = 1'b0; expect_wr(7'h15, 32'h1500);
        tick(); drive(0, 0, 0, 0, 0, 0);
        check("stall_rel_wen", 32'(btb_wen), 32'd1);
        tick(); check("stall_once", 32'(btb_wen), 32'd0);

        // Refresh flushes queue, EX still writes
        drive(1, 7'h40, 32'h4000, 1, 7'h41, 32'h4100); expect_wr(7'h40, 32'h4000);
        tick();
        drive(1, 7'h40, 32'h4001, 1, 7'h42, 32'h4200); expect_wr(7'h40, 32'h4001);
        tick();
        check("rf_qcnt2", 32'(q_count), 32'd2);
        refresh = 1'b1;
        drive(1, 7'h43, 32'h4300, 0, 0, 0); expect_wr(7'h43, 32'h4300);
        tick();
        refresh = 1'b0; drive(0, 0, 0, 0, 0, 0);
        check("rf_qcnt0", 32'(q_count), 32'd0);
        tick(); check("rf_nowr1", 32'(btb_wen), 32'd0);
        tick(); check("rf_nowr2", 32'(btb_wen), 32'd0);

        // Asynchronous reset with fills pending
        for (int k = 0; k < 3; k++) begin
            drive(1, 7'h50, 32'h5000 + 32'(k), 1, 7'(7'h51 + k), 32'h5100 + 32'(k));
            expect_wr(7'h50, 32'h5000 + 32'(k));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        check("mr_qcnt3", 32'(q_count), 32'd3);
        @(negedge clk); #1;
        resetn = 1'b0;
        #1;
        check("mr_wen", 32'(btb_wen), 32'd0);
        check("mr_idx", 32'(btb_windex), 32'd0);
        check("mr_tgt", btb_wtarget, 32'd0);
        check("mr_qcnt", 32'(q_count), 32'd0);
        check("mr_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk); resetn = 1'b1;
        repeat (3) begin
            tick();
            check("mr_nowr", 32'(btb_wen), 32'd0);
            check("mr_qcnt_idle", 32'(q_count), 32'd0);
        end

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bp_btb_wr_arbiter.md
Name: bp_btb_wr_arbiter

Overview:
- Arbitrates the single BTB write port between two requesters.
  - ID-stage BTB fills come from the predecode/ID pipeline register (id_btb_wen/windex/wtarget).
  - EX-stage branch-resolution corrections are the second requester.
- EX corrections have strict priority. ID fills are buffered in a small coalescing FIFO and drained when the port is idle.
- The block sits between the ID/EX stages and the BTB array. It owns BTB write sequencing and the pipeline-flush interaction.

Parameters:
- BTB_W, 7, BTB index width (matches `BTB_LEN).
- QDEPTH, 4, ID fill queue depth (power of two, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- id_stall  in  1  ID register held this cycle; an ID request is valid only when id_stall=0.
- refresh  in  1  pipeline flush.
- id_btb_wen  in  1  ID fill request.
- id_btb_windex  in  BTB_W  ID fill index.
- id_btb_wtarget  in  32  ID fill target.
- ex_btb_wen  in  1  EX correction request.
- ex_btb_windex  in  BTB_W  EX correction index.
- ex_btb_wtarget  in  32  EX correction target.
- btb_wen  out  1  BTB write enable (registered).
- btb_windex  out  BTB_W  BTB write index (registered).
- btb_wtarget  out  32  BTB write target (registered).
- q_count  out  log2(QDEPTH)+1  number of occupied queue slots, killed slots included.
- drop_cnt  out  16  saturating count of ID fills dropped because the queue was full.

Behaviour:
- Reset (async, resetn=0):
  - btb_wen, btb_windex, btb_wtarget, q_count and drop_cnt are 0.
  - All queue entries invalid; head and tail pointers 0.
  - Reset mid-operation discards all pending fills.
- Effective requests:
  - idv = id_btb_wen & ~id_stall & ~refresh.
  - exv = ex_btb_wen.
  - Refresh never blocks EX; corrections are architecturally resolved.
- Issue selection, evaluated each cycle; the result is registered onto the btb_* outputs at the next edge (1-cycle latency):
  1. exv: issue EX.
  2. Otherwise, queue head valid and not killed: pop and issue head.
  3. Otherwise, queue head killed: pop silently, btb_wen=0 next cycle.
  4. Otherwise, queue empty and idv: bypass, issue ID directly (not enqueued).
  5. Otherwise: btb_wen=0. btb_windex and btb_wtarget hold their last values.
- Enqueue, when idv and the ID request was not bypassed:
  - idv with id_btb_windex == ex_btb_windex while exv: ID dropped (EX authoritative); drop_cnt unchanged.
  - Index matches a valid, non-killed entry that is not being popped this cycle: coalesce by overwriting that entry's target. No new slot is used.
  - Else, queue not full after this cycle's pop: write a new entry at the tail.
  - Else: drop, and drop_cnt increments (saturates at 16'hFFFF).
- EX kill: when exv, every valid queued entry whose index equals ex_btb_windex is marked killed. Killed entries still occupy a slot until popped.
- Pop and push in the same cycle on a full queue is allowed: the push succeeds.
- Refresh:
  - All queue entries are invalidated at the edge; q_count=0 next cycle.
  - An EX write selected in the same cycle still issues. Head pop is suppressed.
- Pointers wrap modulo QDEPTH. Full when q_count==QDEPTH; empty when q_count==0.
- Never more than one BTB write per cycle. Queue order is FIFO except for coalescing.

Test Plan:
- Reset mid-operation: queue 3 entries, pulse resetn=0 asynchronously between edges → all outputs 0 immediately; q_count=0; no writes afterwards.
- Bypass: empty queue, idv index 5, target 0x1000 → next cycle btb_wen=1, windex=5, wtarget=0x1000; q_count stays 0.
- Priority and queueing: exv idx 3 and idv idx 9 for 2 consecutive cycles (idx 9 then idx 10):
  - Cycles 1–2: EX writes.
  - Then idx 9 and idx 10 issue in order on cycles 3 and 4.
  - q_count peaks at 2.
- Coalesce and kill:
  - Queue idx 7 (target A), then idx 7 (target B) → single write of B.
  - Separately, queue idx 4 then exv idx 4 → EX write issued, queued idx 4 popped silently (btb_wen=0 that cycle).
- Overflow: hold exv for 6 cycles with idv on distinct indices each cycle → q_count=4, drop_cnt=2. After exv drops, 4 writes drain in FIFO order.
- Stall and flush:
  - id_btb_wen held 3 cycles with id_stall=1 then 0 → exactly one fill issued.
  - refresh with 2 queued entries and exv → only the EX write issues; q_count=0.
